// File: rtl/e203_exu_thread_sched.sv
// Hardware thread scheduler for the multithreaded E203 core.
// Round-robin selection with an instruction quantum. Threads that wait on a
// long-latency operation are marked blocked and skipped. The selection is
// frozen while the pipeline holds a switch-sensitive sequence.
module e203_exu_thread_sched #(
  parameter int THREADS_NUM = 2,
  parameter int TID_W       = 1,
  parameter int QUANTUM     = 1,
  parameter int QCNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [THREADS_NUM-1:0] thr_en,
  input  logic [THREADS_NUM-1:0] thr_block_set,
  input  logic [THREADS_NUM-1:0] thr_block_clr,
  input  logic                   boundary,
  input  logic                   sw_hold,
  output logic [THREADS_NUM-1:0] thread_sel,
  output logic [TID_W-1:0]       thread_id,
  output logic                   sel_vld,
  output logic [THREADS_NUM-1:0] thr_blocked,
  output logic                   switch_evt
);

  // Last count value of a turn; reaching it with a boundary ends the turn.
  localparam logic [QCNT_W-1:0] QMAX   = QCNT_W'(QUANTUM - 1);
  localparam logic [TID_W-1:0]  ID_RST = TID_W'(THREADS_NUM - 1);

  logic [THREADS_NUM-1:0] r_thread_sel;
  logic [TID_W-1:0]       r_thread_id;
  logic [THREADS_NUM-1:0] r_blocked;
  logic                   r_switch_evt;
  logic [QCNT_W-1:0]      r_qcnt;

  logic [THREADS_NUM-1:0] w_ready;
  logic                   w_sel_vld;
  logic                   w_cur_rdy;
  logic                   w_q_exp;
  logic                   w_do_switch;
  logic                   w_found;
  logic [TID_W-1:0]       w_pick;
  logic [TID_W-1:0]       w_idx;
  logic [THREADS_NUM-1:0] w_pick_oh;
  logic [QCNT_W-1:0]      w_qinc;
  logic [THREADS_NUM-1:0] w_nxt_sel;
  logic [TID_W-1:0]       w_nxt_id;
  logic [QCNT_W-1:0]      w_nxt_qcnt;
  logic                   w_nxt_evt;

  // Readiness uses the registered blocked flags only, so a block_set takes
  // one cycle to become a flag and one more to move the selection.
  assign w_ready     = thr_en & ~r_blocked;
  assign w_sel_vld   = |r_thread_sel;
  assign w_cur_rdy   = w_sel_vld & w_ready[r_thread_id];
  assign w_q_exp     = boundary & (r_qcnt >= QMAX);
  assign w_do_switch = ~w_cur_rdy | w_q_exp;
  assign w_pick_oh   = THREADS_NUM'(1) << w_pick;
  assign w_qinc      = (boundary && (r_qcnt < QMAX)) ? r_qcnt + 1'b1 : r_qcnt;

  // Round-robin search: thread_id+1 first, thread_id itself last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= THREADS_NUM; k++) begin
      w_idx = TID_W'((int'(r_thread_id) + k) % THREADS_NUM);
      if (!w_found && w_ready[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Next selection, thread id, quantum count and switch pulse.
  always_comb begin
    w_nxt_sel  = r_thread_sel;
    w_nxt_id   = r_thread_id;
    w_nxt_qcnt = r_qcnt;
    w_nxt_evt  = 1'b0;
    if (!w_sel_vld) begin
      // Idle ignores the hold: nothing is in flight for any thread.
      w_nxt_qcnt = '0;
      if (w_found) begin
        w_nxt_sel = w_pick_oh;
        w_nxt_id  = w_pick;
        w_nxt_evt = 1'b1;
      end
    end else if (sw_hold) begin
      // Frozen; an expired quantum stays saturated until the hold drops.
      w_nxt_qcnt = w_qinc;
    end else if (w_do_switch) begin
      w_nxt_qcnt = '0;
      if (!w_found) begin
        // Going idle keeps thread_id so the next search resumes after it.
        w_nxt_sel = '0;
      end else if (w_pick != r_thread_id) begin
        w_nxt_sel = w_pick_oh;
        w_nxt_id  = w_pick;
        w_nxt_evt = 1'b1;
      end
    end else begin
      w_nxt_qcnt = w_qinc;
    end
  end

  // Selection state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thread_sel <= '0;
      r_thread_id  <= ID_RST;
      r_switch_evt <= 1'b0;
      r_qcnt       <= '0;
    end else begin
      r_thread_sel <= w_nxt_sel;
      r_thread_id  <= w_nxt_id;
      r_switch_evt <= w_nxt_evt;
      r_qcnt       <= w_nxt_qcnt;
    end
  end

  // Blocked flags; a simultaneous set and clear leaves the thread blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocked <= '0;
    end else begin
      r_blocked <= (r_blocked & ~thr_block_clr) | thr_block_set;
    end
  end

  assign thread_sel  = r_thread_sel;
  assign thread_id   = r_thread_id;
  assign sel_vld     = w_sel_vld;
  assign thr_blocked = r_blocked;
  assign switch_evt  = r_switch_evt;

endmodule

// File: doc/e203_exu_thread_sched.md
Name: e203_exu_thread_sched

Overview:
- Hardware thread scheduler for the multithreaded E203 core.
- Produces the one-hot thread_sel that steers every per-thread replicated unit, including the per-thread CSR banks, the PC and the register file.
- Policy: round-robin with a configurable instruction quantum.
- Tracks a per-thread blocked state so that a thread waiting on a long-latency operation is skipped.
- Never switches while the pipeline asserts a hold (CSR/atomic/debug sequence in flight).

Parameters:
- THREADS_NUM, 2, number of hardware threads; equals `E203_THREADS_NUM.
- TID_W, 1, width of thread_id; ceil(log2(THREADS_NUM)), minimum 1.
- QUANTUM, 1, instruction boundaries per turn; legal range 1..15.
- QCNT_W, 4, width of the quantum counter.

Ports:
- clk, input, 1: core clock.
- rst_n, input, 1: asynchronous active-low reset.
- thr_en, input, THREADS_NUM: thread enabled (booted, not parked).
- thr_block_set, input, THREADS_NUM: pulse; thread issued a long-latency op and must wait.
- thr_block_clr, input, THREADS_NUM: pulse; the thread's long-latency op returned.
- boundary, input, 1: pulse; an instruction of the selected thread was accepted at the switch point.
- sw_hold, input, 1: switching forbidden this cycle.
- thread_sel, output, THREADS_NUM: registered one-hot selected thread; all-zero when idle.
- thread_id, output, TID_W: binary index of the current/last selected thread.
- sel_vld, output, 1: thread_sel is nonzero.
- thr_blocked, output, THREADS_NUM: registered blocked flags.
- switch_evt, output, 1: registered pulse, high in the first cycle of a new nonzero selection.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - thread_sel=0, sel_vld=0, thread_id=THREADS_NUM-1, thr_blocked=0, switch_evt=0.
  - Quantum counter qcnt=0.
  - Reset mid-operation discards all state immediately.
- Blocked flags, per thread i:
  - Set by block_set[i].
  - Cleared by block_clr[i].
  - set and clr in the same cycle: set wins.
  - Update is visible in thr_blocked one cycle later.
- Ready vector: ready = thr_en & ~thr_blocked, computed from registered flags.
- cur_rdy = sel_vld & ready[thread_id].
- Search order: first ready thread in order thread_id+1, thread_id+2, … wrapping modulo THREADS_NUM, with thread_id itself checked last.
- Quantum expiry: q_exp = boundary & (qcnt >= QUANTUM-1).
- Next-state decision each cycle:
  - Idle (sel_vld=0), sw_hold ignored:
    - If any thread is ready, the next thread_sel is the first ready thread in search order.
    - Otherwise stay idle.
  - Active, sw_hold=1: keep the selection, even if the current thread became not ready.
  - Active, sw_hold=0, do_switch = ~cur_rdy | q_exp:
    - If do_switch, the next selection is the first ready thread in search order.
    - If the only ready thread is the current one, it is kept with switch_evt=0.
    - If no thread is ready, go idle: thread_sel=0, and thread_id retains the last value.
- Latency:
  - The decision is made combinationally in cycle N; the new thread_sel appears in cycle N+1.
  - A block_set on the selected thread in cycle N sets the flag in N+1; the switch is visible in N+2.
- qcnt:
  - Reset to 0 whenever the next selection differs from the current one, or on entering/leaving idle.
  - A kept selection after do_switch also resets qcnt.
  - Otherwise increments on boundary, saturating at QUANTUM-1.
  - While held, an expired quantum stays saturated; the switch occurs at the first boundary with sw_hold=0.
- thread_id updates together with thread_sel whenever a new nonzero selection is made.
- switch_evt: 1 exactly in the cycle thread_sel becomes a nonzero value different from its previous value; this includes idle→active.
- thr_en deassert of the selected thread: treated as not ready, and switches when hold is released.
- QUANTUM=1: switch on every boundary, giving fine-grained interleave.
- Invariants: thread_sel is always one-hot or zero, and it never selects a thread with thr_en=0 at the decision cycle.

Test Plan:
- Reset, THREADS_NUM=2, QUANTUM=1, thr_en=2'b11, boundary held 1 → first cycle after reset release: thread_sel=01, switch_evt=1; then 10, 01, 10… alternating every cycle, switch_evt=1 each cycle.
- QUANTUM=3, thr_en=11, one boundary per cycle → thread_sel holds 01 for 3 cycles, then 10 for 3 cycles; boundary gaps delay the switch accordingly.
- Thread 1 selected, block_set[1] in cycle N → thr_blocked=10 in N+1, thread_sel=01 in N+2; boundaries keep thread_sel=01 with switch_evt=0; block_clr[1] → alternation resumes at the next quantum expiry.
- block_set=11 → thread_sel=00, sel_vld=0, thread_id unchanged; block_clr[0] → thr_blocked=10 next cycle, thread_sel=01 one cycle later, switch_evt=1.
- QUANTUM=1, sw_hold=1 for 5 cycles with boundary pulses → no change of thread_sel; sw_hold=0 plus boundary → switch next cycle; current thread blocked under hold → selection kept until hold drops.
- block_set[0] and block_clr[0] in the same cycle while thread 0 is blocked → stays blocked; rst_n low mid-run → all outputs 0 asynchronously, thread_id=1; release → thread 0 selected first.
